// File: rtl/disp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | disp_pkg : glyphs and anode constants for the 7-seg display mux |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package disp_pkg;

   // Active-low glyphs ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF    = 4'b1111;

   function automatic logic [3:0] an_sel(input logic [1:0] idx);
      an_sel = ~(4'b0001 << idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_sseg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_to_sseg : BCD to active-low glyph, dash for values 10..15   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bcd_to_sseg
   import disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/disp_mux_bcd.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | disp_mux_bcd : 4-digit multiplexed common-anode display driver  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module disp_mux_bcd
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   input  logic       lzb,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   localparam int            CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] c_cnt_max = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_snap3, r_snap2, r_snap1, r_snap0;
   logic [3:0]    r_snap_dp;

   logic       w_tick;
   logic       w_snap_load;
   logic [1:0] w_idx_nxt;
   logic [3:0] w_digit;
   logic       w_dp;
   logic       w_blank;
   logic [6:0] w_glyph;

   assign w_tick      = (r_cnt == c_cnt_max);
   assign w_idx_nxt   = r_idx + 2'd1;
   assign w_snap_load = w_tick && (r_idx == 2'd3);

   // Digit 0 is lit on the same edge the snapshot loads, so it reads the live inputs.
   always_comb begin
      w_digit = d0;
      w_dp    = dp_in[0];
      w_blank = 1'b0;
      case (w_idx_nxt)
         2'd0: begin
            w_digit = d0;
            w_dp    = dp_in[0];
         end
         2'd1: begin
            w_digit = r_snap1;
            w_dp    = r_snap_dp[1];
            w_blank = lzb && (r_snap3 == 4'd0) && (r_snap2 == 4'd0) && (r_snap1 == 4'd0);
         end
         2'd2: begin
            w_digit = r_snap2;
            w_dp    = r_snap_dp[2];
            w_blank = lzb && (r_snap3 == 4'd0) && (r_snap2 == 4'd0);
         end
         default: begin
            w_digit = r_snap3;
            w_dp    = r_snap_dp[3];
            w_blank = lzb && (r_snap3 == 4'd0);
         end
      endcase
   end

   bcd_to_sseg u_dec (
      .bcd (w_digit),
      .seg (w_glyph)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_idx     <= 2'd3;
         r_snap3   <= 4'd0;
         r_snap2   <= 4'd0;
         r_snap1   <= 4'd0;
         r_snap0   <= 4'd0;
         r_snap_dp <= 4'd0;
         an        <= AN_OFF;
         sseg      <= 8'hFF;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_snap_load) begin
            r_snap3   <= d3;
            r_snap2   <= d2;
            r_snap1   <= d1;
            r_snap0   <= d0;
            r_snap_dp <= dp_in;
         end
         if (w_tick) begin
            r_idx <= w_idx_nxt;
            an    <= an_sel(w_idx_nxt);
            sseg  <= {~w_dp, (w_blank ? SEG_BLANK : w_glyph)};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_bcd.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_disp_mux_bcd : randomized bench with a frame-level model     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_disp_mux_bcd;

   localparam int RD = 4;

   logic       clk;
   logic       reset_n;
   logic [3:0] d3, d2, d1, d0;
   logic [3:0] dp_in;
   logic       lzb;
   logic [3:0] an;
   logic [7:0] sseg;

   disp_mux_bcd #(.REFRESH_DIV(RD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .d3      (d3),
      .d2      (d2),
      .d1      (d1),
      .d0      (d0),
      .dp_in   (dp_in),
      .lzb     (lzb),
      .an      (an),
      .sseg    (sseg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: cycles since reset release, the frame's captured digits and expected pins.
   int         cyc;
   logic [3:0] ms[4];
   logic [3:0] msdp;
   logic [3:0] exp_an;
   logic [7:0] exp_sseg;
   logic [6:0] glyph[16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 4; i++) ms[i] = 4'd0;
      msdp     = 4'd0;
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
   endtask

   task automatic model_edge();
      int   dig;
      logic blank;
      cyc++;
      if (cyc % RD == 0) begin
         dig = ((cyc / RD) - 1) % 4;
         if (dig == 0) begin
            ms[0] = d0; ms[1] = d1; ms[2] = d2; ms[3] = d3;
            msdp  = dp_in;
         end
         blank = lzb && (dig != 0);
         for (int j = dig; j < 4; j++)
            if (ms[j] != 4'd0) blank = 1'b0;
         exp_an   = 4'hF & ~(4'b0001 << dig);
         exp_sseg = {~msdp[dig], (blank ? 7'h7F : glyph[ms[dig]])};
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset_n) model_edge();
      @(negedge clk);
      check("an", 32'(an), 32'(exp_an));
      check("sseg", 32'(sseg), 32'(exp_sseg));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_d(input logic [3:0] a3, a2, a1, a0, input logic [3:0] dp, input logic lz);
      d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_in = dp; lzb = lz;
   endtask

   task automatic wait_an(input logic [3:0] target, input string tag);
      int k;
      k = 0;
      while (exp_an != target && k < 64) begin
         step();
         k++;
      end
      if (k >= 64) check(tag, 32'(exp_an), 32'(target));
   endtask

   task automatic restart_check();
      for (int i = 0; i < 3; i++) begin
         step();
         check("pre_first_tick_an", 32'(an), 32'hF);
      end
      step();
      check("first_lit_an", 32'(an), 32'hE);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) glyph[i] = 7'b0111111;
      glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
      glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
      glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
      glyph[9] = 7'b0010000;

      reset_n = 1'b0;
      set_d(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_an", 32'(an), 32'hF);
      check("reset_sseg", 32'(sseg), 32'hFF);
      reset_n = 1'b1;
      restart_check();
      check("first_sseg_d0_4", 32'(sseg), 32'h99);

      run(32);

      set_d(4'd0, 4'd0, 4'd0, 4'd7, 4'b0100, 1'b1);
      wait_an(4'h7, "wait_d3_a");
      run(32);

      set_d(4'd0, 4'd0, 4'hC, 4'd0, 4'b0000, 1'b1);
      wait_an(4'h7, "wait_d3_b");
      run(32);

      set_d(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
      wait_an(4'h7, "wait_d3_c");
      run(32);

      // Change inputs while digit 1 is lit; current frame must keep old digits.
      set_d(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
      run(32);
      wait_an(4'hD, "wait_d1");
      set_d(4'd5, 4'd6, 4'd7, 4'd8, 4'b0000, 1'b0);
      run(40);

      wait_an(4'hB, "wait_d2");
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_an", 32'(an), 32'hF);
      check("async_rst_sseg", 32'(sseg), 32'hFF);
      @(negedge clk);
      reset_n = 1'b1;
      restart_check();

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            d3 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            d2 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            d1 = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            d0 = 4'($urandom_range(0, 15));
            dp_in = 4'($urandom_range(0, 15));
            lzb   = 1'($urandom_range(0, 1));
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
